fft_frame_seq: RTL and testbench
================================

# fft_frame_seq

Sequencer for the streaming FFT core in the AB-side spectrum path. On a start request it writes the FFT configuration word, streams exactly one frame of ADC samples into the core with correct AXI-Stream valid/last framing, then waits until the core has emitted the matching output frame. It replaces the free-running "tvalid tied high" arrangement, so the downstream modulus and peak-search logic always sees aligned, complete frames. It sits between the ADC capture and the FFT IP, in the FFT clock domain.

## Interface
- FFT_LEN, 4096, transform length in samples; power of two, at least 8
- CNT_W, 13, counter width; must hold FFT_LEN
- DATA_W, 10, ADC sample width
- CFG_WORD, 8'd1, value driven on the config channel (forward transform)
- TIMEOUT, 20000, WAIT_OUT watchdog limit in cycles; used only with FFT_SEQ_TIMEOUT_EN

Ports:
- fft_clk  in  1  single clock; all logic on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  level or pulse; sampled only in IDLE
- continuous  in  1  1 = re-arm automatically after each frame
- ad_data  in  DATA_W  unsigned ADC sample
- cfg_tdata  out  8  FFT config word
- cfg_tvalid  out  1  config valid
- cfg_tready  in  1  config ready
- s_tdata  out  32  {16'h0000 imag, zero-extended ad_data real}; combinational from ad_data
- s_tvalid  out  1  sample valid
- s_tready  in  1  FFT accepts sample
- s_tlast  out  1  last sample of frame
- m_tvalid  in  1  FFT output beat valid (downstream is always ready)
- m_tlast  in  1  FFT output last beat
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse when an output frame completes
- frame_cnt  out  16  completed frames, wraps at 65535 to 0
- err_frame  out  1  one-cycle pulse on an output framing mismatch
- timeout  out  1  one-cycle pulse on watchdog expiry (0 without the macro)

## Operation
- States: IDLE, CFG, LOAD, WAIT_OUT, DONE.
- IDLE: if start=1, go to CFG. Outputs are quiet.
- CFG: cfg_tvalid=1, cfg_tdata=CFG_WORD. When cfg_tvalid and cfg_tready are both high, go to LOAD and clear in_cnt.
- LOAD: s_tvalid=1. A beat is counted when s_tvalid and s_tready are both high; in_cnt increments on that beat.
  - s_tlast=1 exactly when in_cnt==FFT_LEN-1.
  - The tlast beat clears in_cnt and out_cnt and moves to WAIT_OUT.
- WAIT_OUT: out_cnt increments on each m_tvalid.
  - On m_tvalid and m_tlast: if out_cnt!=FFT_LEN-1, pulse err_frame. In either case go to DONE.
  - m_tvalid outside WAIT_OUT is ignored.
- DONE (one cycle): pulse frame_done and increment frame_cnt.
  - Next state is LOAD if continuous=1 (config is not rewritten). Otherwise next state is IDLE.
- start is ignored while busy.
- continuous is sampled only in DONE.

## Timing
- Reset values: all state is IDLE; cfg_tvalid, s_tvalid, s_tlast, busy, frame_done, err_frame and timeout are 0; frame_cnt is 0; cfg_tdata is CFG_WORD.
- Reset mid-frame drops s_tvalid asynchronously. No partial frame is completed.
- Latencies:
  - start high to cfg_tvalid: 1 cycle.
  - cfg handshake to first s_tvalid: 1 cycle.
  - m_tlast beat to frame_done: 1 cycle.
- Control outputs (s_tvalid, s_tlast, cfg_tvalid) are registered state decodes. s_tvalid is not withdrawn before the handshake completes.
- Backpressure: while s_tready=0, in_cnt and s_tlast hold their values.
- With s_tready held high, a frame occupies exactly FFT_LEN consecutive LOAD cycles.
- In continuous mode the gap between frames is DONE (1 cycle) plus the core latency.

## Configuration
- FFT_SEQ_TIMEOUT_EN defined:
  - A watchdog counter clears on entry to WAIT_OUT and counts every cycle spent there.
  - When it reaches TIMEOUT-1 with no m_tlast, pulse timeout and go to IDLE. frame_cnt is unchanged and continuous is ignored.
  - An m_tlast in that same cycle takes priority: the frame completes normally.
- FFT_SEQ_TIMEOUT_EN undefined: no watchdog. WAIT_OUT waits indefinitely, and timeout is tied to 0.

## Test plan
- Nominal frame: FFT_LEN=8, s_tready=1, start pulse, model emits 8 m_tvalid beats with the last one flagged.
  - Required: 1 cfg beat with tdata=8'h01, then 8 s beats with tlast on beat 8, then frame_done once, frame_cnt=1, busy low after DONE.
- Backpressure: toggle s_tready every other cycle.
  - Required: exactly 8 accepted beats, tlast only on the 8th accepted beat, s_tvalid never drops mid-frame.
- Framing error: model asserts m_tlast on output beat 6.
  - Required: err_frame pulses once, frame_done still pulses, frame_cnt=1.
- Continuous: continuous=1 for 3 frames, cfg_tready low for 5 cycles at the start.
  - Required: cfg written once only; 3 frame_done pulses; frame_cnt=3; re-arm LOAD follows DONE by 1 cycle.
- Reset mid-LOAD: assert rst_n=0 at accepted beat 4.
  - Required: s_tvalid goes to 0 immediately, all outputs take reset values, and the next start yields a clean 8-beat frame.
- Timeout (macro on, TIMEOUT=16): the model never sends m_tlast.
  - Required: timeout pulses 16 cycles after WAIT_OUT entry, state returns to IDLE, frame_cnt=0.

Source files
------------

// File: rtl/fft_frame_seq.sv
// Frame sequencer for the streaming FFT core: writes the config word, streams one framed
// block of ADC samples, then waits for the matching output frame. Optional watchdog: FFT_SEQ_TIMEOUT_EN.
module fft_frame_seq #(
    parameter int          FFT_LEN  = 4096,
    parameter int          CNT_W    = 13,
    parameter int          DATA_W   = 10,
    parameter logic [7:0]  CFG_WORD = 8'd1,
    parameter int          TIMEOUT  = 20000
) (
    input  logic              fft_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              continuous,
    input  logic [DATA_W-1:0] ad_data,
    output logic [7:0]        cfg_tdata,
    output logic              cfg_tvalid,
    input  logic              cfg_tready,
    output logic [31:0]       s_tdata,
    output logic              s_tvalid,
    input  logic              s_tready,
    output logic              s_tlast,
    input  logic              m_tvalid,
    input  logic              m_tlast,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       frame_cnt,
    output logic              err_frame,
    output logic              timeout
);
    typedef enum logic [2:0] {IDLE, CFG, LOAD, WAIT_OUT, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(FFT_LEN - 1);

    state_t           state;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] out_cnt;

    assign cfg_tdata = CFG_WORD;
    // Real part is the unsigned ADC sample, imaginary part is zero.
    assign s_tdata   = {16'h0000, 16'(ad_data)};

`ifdef FFT_SEQ_TIMEOUT_EN
    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    logic [WD_W-1:0] wd;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge fft_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_cnt     <= '0;
            out_cnt    <= '0;
            cfg_tvalid <= 1'b0;
            s_tvalid   <= 1'b0;
            s_tlast    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err_frame  <= 1'b0;
            frame_cnt  <= '0;
`ifdef FFT_SEQ_TIMEOUT_EN
            wd         <= '0;
            timeout    <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            err_frame  <= 1'b0;
`ifdef FFT_SEQ_TIMEOUT_EN
            timeout    <= 1'b0;
`endif
            case (state)
                IDLE: if (start) begin
                    state      <= CFG;
                    cfg_tvalid <= 1'b1;
                    busy       <= 1'b1;
                end
                CFG: if (cfg_tvalid && cfg_tready) begin
                    state      <= LOAD;
                    cfg_tvalid <= 1'b0;
                    s_tvalid   <= 1'b1;
                    in_cnt     <= '0;
                end
                LOAD: if (s_tvalid && s_tready) begin
                    if (in_cnt == LAST) begin
                        state    <= WAIT_OUT;
                        s_tvalid <= 1'b0;
                        s_tlast  <= 1'b0;
                        in_cnt   <= '0;
                        out_cnt  <= '0;
`ifdef FFT_SEQ_TIMEOUT_EN
                        wd       <= '0;
`endif
                    end else begin
                        // tlast is registered, so decode it from the count we are about to hold.
                        in_cnt  <= in_cnt + CNT_W'(1);
                        s_tlast <= ((in_cnt + CNT_W'(1)) == LAST);
                    end
                end
                WAIT_OUT: begin
                    if (m_tvalid) out_cnt <= out_cnt + CNT_W'(1);
                    if (m_tvalid && m_tlast) begin
                        err_frame  <= (out_cnt != LAST);
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 16'd1;
                        state      <= DONE;
                    end
`ifdef FFT_SEQ_TIMEOUT_EN
                    else if (wd == WD_LAST) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
`endif
                end
                DONE: if (continuous) begin
                    state    <= LOAD;
                    s_tvalid <= 1'b1;
                    s_tlast  <= 1'b0;
                    in_cnt   <= '0;
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_frame_seq.sv
// Directed bench for fft_frame_seq with FFT_LEN=8: a tlast scoreboard checks every accepted
// input beat while the main sequence plays the FFT output side.
module tb_fft_frame_seq;
    localparam int LEN = 8;

    logic        fft_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic [9:0]  ad_data = '0;
    logic [7:0]  cfg_tdata;
    logic        cfg_tvalid;
    logic        cfg_tready = 1'b1;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready = 1'b1;
    logic        s_tlast;
    logic        m_tvalid = 1'b0;
    logic        m_tlast = 1'b0;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        err_frame;
    logic        timeout;

    int n_vec = 0;
    int n_err = 0;
    int cfg_beats = 0, s_beats = 0, done_pulses = 0, err_pulses = 0, to_pulses = 0;
    logic in_frame = 1'b0;
    logic bp_mode = 1'b0;
    logic exp_last;
    logic q[$];

    fft_frame_seq #(.FFT_LEN(LEN), .CNT_W(4), .DATA_W(10), .CFG_WORD(8'd1), .TIMEOUT(16)) dut (
        .fft_clk(fft_clk), .rst_n(rst_n), .start(start), .continuous(continuous),
        .ad_data(ad_data), .cfg_tdata(cfg_tdata), .cfg_tvalid(cfg_tvalid),
        .cfg_tready(cfg_tready), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tready(s_tready), .s_tlast(s_tlast), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
        .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt),
        .err_frame(err_frame), .timeout(timeout)
    );

    always #5 fft_clk = ~fft_clk;

    initial begin
        #400000;
        $display("FAIL global_time_limit: got still running, expected finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor samples mid-cycle; a handshake seen here completes on the next rising edge.
    always @(negedge fft_clk) begin
        if (!rst_n) begin
            in_frame = 1'b0;
        end else begin
            if (cfg_tvalid && cfg_tready) begin
                cfg_beats++;
                chk("cfg_tdata", cfg_tdata, 32'h01);
            end
            if (in_frame) chk("s_tvalid_hold", s_tvalid, 1);
            if (s_tvalid && s_tready) begin
                s_beats++;
                chk("s_tdata", s_tdata, {16'h0000, 6'h00, ad_data});
                if (q.size() > 0) begin
                    exp_last = q.pop_front();
                    chk("s_tlast", s_tlast, exp_last);
                end else begin
                    chk("s_beat_expected", q.size(), 1);
                end
                in_frame = !s_tlast;
            end
            if (frame_done) done_pulses++;
            if (err_frame)  err_pulses++;
            if (timeout)    to_pulses++;
        end
    end

    task automatic step();
        @(posedge fft_clk);
        #1;
        ad_data = 10'($urandom);
        if (bp_mode) s_tready = ~s_tready;
    endtask

    task automatic push_frames(input int n);
        for (int f = 0; f < n; f++)
            for (int i = 0; i < LEN; i++) q.push_back(i == LEN - 1);
    endtask

    task automatic clear_counts();
        cfg_beats = 0; s_beats = 0; done_pulses = 0; err_pulses = 0; to_pulses = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; continuous = 1'b0; m_tvalid = 1'b0; m_tlast = 1'b0;
        cfg_tready = 1'b1; s_tready = 1'b1; bp_mode = 1'b0;
        q.delete();
        step(); step();
        chk("rst_cfg_tvalid", cfg_tvalid, 0);
        chk("rst_s_tvalid", s_tvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_cfg_tdata", cfg_tdata, 32'h01);
        rst_n = 1'b1;
        step();
        clear_counts();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_beats(input string tag, input int n);
        int c = 0;
        while (s_beats < n && c < 200) begin step(); c++; end
        chk(tag, s_beats, n);
    endtask

    // Drives n output beats, flagging m_tlast on beat last_at.
    task automatic send_out(input int n, input int last_at);
        for (int i = 1; i <= n; i++) begin
            m_tvalid = 1'b1;
            m_tlast  = (i == last_at);
            step();
        end
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
    endtask

    initial begin
        // Nominal frame
        do_reset();
        chk("rst_s_tlast", s_tlast, 0);
        chk("rst_pulses", {frame_done, err_frame, timeout}, 0);
        push_frames(1);
        pulse_start();
        chk("start_to_cfg", cfg_tvalid, 1);
        step();
        chk("cfg_to_load", s_tvalid, 1);
        wait_beats("nom_beats", LEN);
        chk("nom_wait_out", {busy, s_tvalid}, 2'b10);
        send_out(LEN, LEN);
        chk("nom_done_lat", frame_done, 1);
        step(); step();
        chk("nom_cfg_beats", cfg_beats, 1);
        chk("nom_done_pulses", done_pulses, 1);
        chk("nom_err_pulses", err_pulses, 0);
        chk("nom_frame_cnt", frame_cnt, 1);
        chk("nom_busy_idle", busy, 0);

        // Backpressure on the sample channel
        do_reset();
        push_frames(1);
        pulse_start();
        bp_mode = 1'b1;
        wait_beats("bp_beats", LEN);
        bp_mode = 1'b0;
        s_tready = 1'b1;
        chk("bp_queue_drained", q.size(), 0);
        send_out(LEN, LEN);
        step();
        chk("bp_frame_cnt", frame_cnt, 1);

        // Output framing error: tlast on beat 6
        do_reset();
        push_frames(1);
        pulse_start();
        wait_beats("ferr_beats", LEN);
        send_out(6, 6);
        step(); step();
        chk("ferr_err_pulses", err_pulses, 1);
        chk("ferr_done_pulses", done_pulses, 1);
        chk("ferr_frame_cnt", frame_cnt, 1);

        // Continuous mode with a stalled config channel
        do_reset();
        continuous = 1'b1;
        cfg_tready = 1'b0;
        push_frames(3);
        pulse_start();
        for (int i = 0; i < 5; i++) step();
        chk("cont_cfg_stall", {cfg_tvalid, s_tvalid}, 2'b10);
        cfg_tready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            wait_beats($sformatf("cont_beats_%0d", f), LEN * (f + 1));
            if (f == 2) continuous = 1'b0;
            send_out(LEN, LEN);
            chk($sformatf("cont_done_%0d", f), frame_done, 1);
            step();
            chk($sformatf("cont_rearm_%0d", f), s_tvalid, (f < 2) ? 1 : 0);
        end
        step();
        chk("cont_cfg_beats", cfg_beats, 1);
        chk("cont_done_pulses", done_pulses, 3);
        chk("cont_frame_cnt", frame_cnt, 3);
        chk("cont_busy", busy, 0);

        // Reset in the middle of LOAD
        do_reset();
        push_frames(1);
        ad_data = 10'h3FF;
        pulse_start();
        wait_beats("mid_beats", 4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_s_tvalid", s_tvalid, 0);
        chk("mid_rst_outs", {cfg_tvalid, s_tlast, busy, frame_done, err_frame, timeout}, 0);
        chk("mid_rst_frame_cnt", frame_cnt, 0);
        q.delete();
        step();
        rst_n = 1'b1;
        step();
        clear_counts();
        push_frames(1);
        pulse_start();
        wait_beats("mid_clean_beats", LEN);
        send_out(LEN, LEN);
        step();
        chk("mid_clean_frame_cnt", frame_cnt, 1);
        chk("mid_clean_done", done_pulses, 1);

        // Output side never sends m_tlast
        do_reset();
        push_frames(1);
        pulse_start();
        wait_beats("to_beats", LEN);
        m_tvalid = 1'b1;
`ifdef FFT_SEQ_TIMEOUT_EN
        for (int i = 0; i < 15; i++) step();
        chk("to_not_yet", {timeout, busy}, 2'b01);
        step();
        m_tvalid = 1'b0;
        chk("to_pulse", {timeout, busy}, 2'b10);
        step(); step();
        chk("to_pulses", to_pulses, 1);
        chk("to_frame_cnt", frame_cnt, 0);
        chk("to_idle_cfg", cfg_tvalid, 0);
`else
        for (int i = 0; i < 40; i++) step();
        m_tvalid = 1'b0;
        chk("nowd_still_busy", busy, 1);
        chk("nowd_timeout", to_pulses, 0);
        send_out(LEN, LEN);
        step();
        chk("nowd_frame_cnt", frame_cnt, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
